led_ctrl: RTL

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/led_ctrl.sv
// LED channel controller: per-channel OFF / ON / BLINK / PWM drive.
// A shared prescaler produces a one-cycle timebase tick that clocks the
// blink timers; a shared free-running counter is the PWM reference.
// Configuration arrives as one-cycle valid/ready writes addressed by
// channel index. Out-of-range indices are rejected with a cfg_err pulse.

module led_ctrl #(
  parameter int NUM_LED        = 4,
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int PWM_BITS       = 8,
  parameter int DEFAULT_PERIOD = 500
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [15:0]         cfg_period,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                cfg_err,
  output logic [NUM_LED-1:0]  led
);

  localparam int PRESC_DIV = CLK_FREQ_HZ / TICK_HZ;
  // A divide ratio of 1 degenerates to a 1-bit counter pinned at 0, i.e. tick every cycle.
  localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_DIV - 1);
  localparam logic [4:0] NUM_LED_W = 5'(NUM_LED);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                cfg_err_q, cfg_err_d;
  logic [NUM_LED-1:0]  led_q, led_d;

  mode_e               mode_q   [NUM_LED];
  mode_e               mode_d   [NUM_LED];
  logic [15:0]         period_q [NUM_LED];
  logic [15:0]         period_d [NUM_LED];
  logic [PWM_BITS-1:0] duty_q   [NUM_LED];
  logic [PWM_BITS-1:0] duty_d   [NUM_LED];
  logic [15:0]         cnt_q    [NUM_LED];
  logic [15:0]         cnt_d    [NUM_LED];
  logic                phase_q  [NUM_LED];
  logic                phase_d  [NUM_LED];

  logic tick;
  logic wr_fire;
  logic chan_ok;

  // Period 0 is treated like period 1: the phase toggles on every tick.
  function automatic logic [15:0] blink_limit(input logic [15:0] p);
    return (p == 16'd0) ? 16'd0 : p - 16'd1;
  endfunction

  assign tick      = (presc_q == PRESC_MAX);
  assign wr_fire   = cfg_valid && cfg_ready_q;
  assign chan_ok   = ({1'b0, cfg_chan} < NUM_LED_W);
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign led       = led_q;

  // Shared timebase, PWM reference, handshake and error pulse.
  always_comb begin
    presc_d     = tick ? '0 : presc_q + PRESC_W'(1);
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    cfg_ready_d = 1'b1;
    cfg_err_d   = wr_fire && !chan_ok;
  end

  // Per-channel state: a write to this channel wins over a coincident tick.
  always_comb begin
    for (int i = 0; i < NUM_LED; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      cnt_d[i]    = cnt_q[i];
      phase_d[i]  = phase_q[i];
      if (wr_fire && chan_ok && (cfg_chan == 4'(i))) begin
        mode_d[i]   = mode_e'(cfg_mode);
        period_d[i] = cfg_period;
        duty_d[i]   = cfg_duty;
        cnt_d[i]    = 16'd0;
        phase_d[i]  = 1'b1;
      end else if (tick && (mode_q[i] == MODE_BLINK)) begin
        if (cnt_q[i] >= blink_limit(period_q[i])) begin
          cnt_d[i]   = 16'd0;
          phase_d[i] = ~phase_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // LED drive decoded from the current channel state; registered below.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      case (mode_q[i])
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = phase_q[i];
        MODE_PWM:   led_d[i] = (pwm_cnt_q < duty_q[i]);
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      led_q       <= '0;
      for (int i = 0; i < NUM_LED; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= 16'(DEFAULT_PERIOD);
        duty_q[i]   <= '0;
        cnt_q[i]    <= '0;
        phase_q[i]  <= 1'b0;
      end
    end else begin
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      led_q       <= led_d;
      for (int i = 0; i < NUM_LED; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        cnt_q[i]    <= cnt_d[i];
        phase_q[i]  <= phase_d[i];
      end
    end
  end

endmodule
